// File: rtl/seg7_capture.sv
// seg7_capture: reads back a multiplexed 7-segment display bus.
// Segment lines and one-hot digit strobes are synchronised, then held stable
// for STABLE_CYCLES samples, then decoded back to a hex nibble per digit.
module seg7_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3,
  parameter int ACTIVE_LOW    = 0,
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              segments,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  input  logic                    err_clear,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    upd_valid,
  output logic [IDX_W-1:0]        upd_idx,
  output logic [3:0]              upd_nibble,
  output logic                    upd_err,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t                  state, state_n;
  logic [6:0]              seg_in, seg_p0, s_seg, ref_seg;
  logic [NUM_DIGITS-1:0]   sel_in, sel_p0, s_sel, ref_sel;
  logic [NUM_DIGITS-1:0]   seen;
  logic [CNT_W-1:0]        cnt, cnt_n, cnt_inc;
  logic                    sel_ok, match, load, commit;
  logic [4:0]              dec;
  logic                    bad_glyph;

  // Exact-match glyph lookup; returns {known, nibble}
  function automatic logic [4:0] decode7(input logic [6:0] g);
    logic [4:0] r;
    case (g)
      7'h3F: r = 5'h10;  7'h06: r = 5'h11;  7'h5B: r = 5'h12;  7'h4F: r = 5'h13;
      7'h66: r = 5'h14;  7'h6D: r = 5'h15;  7'h7D: r = 5'h16;  7'h07: r = 5'h17;
      7'h7F: r = 5'h18;  7'h6F: r = 5'h19;  7'h77: r = 5'h1A;  7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;  7'h5E: r = 5'h1D;  7'h79: r = 5'h1E;  7'h71: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Position of the set bit in a one-hot strobe
  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_DIGITS-1:0] s);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (s[i]) r = IDX_W'(i);
    return r;
  endfunction

  assign seg_in    = (ACTIVE_LOW != 0) ? ~segments  : segments;
  assign sel_in    = (ACTIVE_LOW != 0) ? ~digit_sel : digit_sel;
  assign sel_ok    = $onehot(s_sel);
  assign match     = (s_seg == ref_seg) && (s_sel == ref_sel);
  assign cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign dec       = decode7(s_seg);
  assign bad_glyph = !dec[4] && (s_seg != 7'h00);

  // Two-flop synchroniser on all segment and strobe lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_p0 <= '0;
      sel_p0 <= '0;
      s_seg  <= '0;
      s_sel  <= '0;
    end else begin
      seg_p0 <= seg_in;
      sel_p0 <= sel_in;
      s_seg  <= seg_p0;
      s_sel  <= sel_p0;
    end
  end

  // FSM state, stability counter and reference sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ref_seg <= '0;
      ref_sel <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) begin
        ref_seg <= s_seg;
        ref_sel <= s_sel;
      end
    end
  end

  // Next-state: restart the count on any change, commit once per stable run
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (sel_ok) begin
          load = 1'b1;
          if (STABLE_CYCLES == 1) begin
            commit  = 1'b1;
            state_n = HOLD;
          end else begin
            cnt_n   = CNT_W'(1);
            state_n = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (!sel_ok) begin
          state_n = IDLE;
        end else if (!match) begin
          load  = 1'b1;
          cnt_n = CNT_W'(1);
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc >= CNT_TGT) begin
            commit  = 1'b1;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (!match) begin
          if (!sel_ok) begin
            state_n = IDLE;
          end else begin
            load    = 1'b1;
            cnt_n   = CNT_W'(1);
            state_n = SETTLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Commit bookkeeping: per-digit value/valid/error, update pulse, frame tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits      <= '0;
      digit_valid <= '0;
      digit_err   <= '0;
      upd_valid   <= 1'b0;
      upd_idx     <= '0;
      upd_nibble  <= '0;
      upd_err     <= 1'b0;
      frame_done  <= 1'b0;
      seen        <= '0;
    end else begin
      upd_valid  <= commit;
      frame_done <= 1'b0;
      digit_err  <= err_clear ? '0 : digit_err;
      if (commit) begin
        upd_idx    <= onehot_idx(s_sel);
        upd_nibble <= dec[4] ? dec[3:0] : 4'h0;
        upd_err    <= bad_glyph;
        for (int d = 0; d < NUM_DIGITS; d++) begin
          if (s_sel[d]) begin
            if (dec[4]) begin
              digits[4*d +: 4] <= dec[3:0];
              digit_valid[d]   <= 1'b1;
            end else begin
              digit_valid[d] <= 1'b0;
              if (bad_glyph) digit_err[d] <= 1'b1;
            end
          end
        end
        if ((seen | s_sel) == {NUM_DIGITS{1'b1}}) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen <= seen | s_sel;
        end
      end
    end
  end

endmodule
